mdu_ctrl: RTL and testbench

Multiply/divide sequencer for the execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E, runs a 2-cycle multiply or a 32-iteration restoring divide, owns the HI/LO register pair, and stalls the pipeline while an operation is in flight. Exceptions and ERET flush it from M. The decoder's aluop encoding selects the operation.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/div_iter.sv | 25 ++
 rtl/mdu_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op encodings used by the decoder and the
// multiply/divide sequencer's state type and helpers.
package cpu_pkg;

    localparam logic [7:0] ALU_DIV   = 8'h06;
    localparam logic [7:0] ALU_DIVU  = 8'h07;
    localparam logic [7:0] ALU_MULT  = 8'h08;
    localparam logic [7:0] ALU_MULTU = 8'h09;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    // Two's-complement negate when neg is set, pass through otherwise.
    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// One restoring-divide step: shift {rem, quo} left, then conditionally
// subtract the divisor and shift in the quotient bit.
module div_iter (
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] quo_next
);

    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic        ge;

    assign rem_sh = {rem, quo[31]};

    // Bit 32 of the shifted remainder is folded in separately: if it is set
    // the remainder certainly exceeds any 32-bit divisor.
    assign diff = {1'b0, rem_sh[31:0]} - {1'b0, divisor};
    assign ge   = rem_sh[32] | ~diff[32];

    assign rem_next = ge ? diff[31:0] : rem_sh[31:0];
    assign quo_next = {quo[30:0], ge};

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: 2-cycle multiply, 32-step restoring divide,
// owns HI/LO and stalls F/D/E while an operation is in flight.
module mdu_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_i,
    input  logic [7:0]  aluop_i,
    input  logic        mthi_i,
    input  logic        mtlo_i,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    mdu_state_t state_reg, state_next;

    logic        is_mul_op;
    logic        is_div_op;
    logic        start;
    logic        idle_issue;

    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic        signed_reg;
    logic        div_op_reg;
    logic [31:0] divisor_reg;
    logic [31:0] rem_reg;
    logic [31:0] quo_reg;
    logic        q_neg_reg;
    logic        r_neg_reg;
    logic [5:0]  count_reg;
    logic [63:0] prod_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    logic        div_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] prod_next;
    logic [31:0] rem_next;
    logic [31:0] quo_next;

    assign is_mul_op  = (aluop_i == ALU_MULT) | (aluop_i == ALU_MULTU);
    assign is_div_op  = (aluop_i == ALU_DIV)  | (aluop_i == ALU_DIVU);
    assign idle_issue = valid_i & ~flush_i & (state_reg == IDLE);
    assign start      = idle_issue & (is_mul_op | is_div_op);

    // A zero divisor turns sign handling off, so DIV x/0 yields HI = x, LO = ~0.
    assign div_signed = (aluop_i == ALU_DIV) & (src_b != 32'd0);
    assign a_mag      = neg_if(div_signed & src_a[31], src_a);
    assign b_mag      = neg_if(div_signed & src_b[31], src_b);

    assign prod_next = signed_reg
        ? 64'($signed({{32{a_reg[31]}}, a_reg}) * $signed({{32{b_reg[31]}}, b_reg}))
        : ({32'd0, a_reg} * {32'd0, b_reg});

    div_iter u_div_iter (
        .rem      (rem_reg),
        .quo      (quo_reg),
        .divisor  (divisor_reg),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        stall_o    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = is_mul_op ? MUL : DIV;
                end
            end
            MUL:  state_next = DONE;
            DIV: begin
                if (count_reg == 6'd31) begin
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush_i) begin
            state_next = IDLE;
        end
        stall_o = (start | (state_reg == MUL) | (state_reg == DIV)) & ~flush_i;
    end

    assign busy_o = (state_reg != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_reg       <= '0;
            b_reg       <= '0;
            signed_reg  <= 1'b0;
            div_op_reg  <= 1'b0;
            divisor_reg <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
            count_reg   <= '0;
            prod_reg    <= '0;
        end else if (start) begin
            a_reg       <= src_a;
            b_reg       <= src_b;
            signed_reg  <= (aluop_i == ALU_MULT) | (aluop_i == ALU_DIV);
            div_op_reg  <= is_div_op;
            divisor_reg <= b_mag;
            rem_reg     <= '0;
            quo_reg     <= a_mag;
            q_neg_reg   <= div_signed & (src_a[31] ^ src_b[31]);
            r_neg_reg   <= div_signed & src_a[31];
            count_reg   <= '0;
        end else if (!flush_i) begin
            if (state_reg == MUL) begin
                prod_reg <= prod_next;
            end
            if (state_reg == DIV) begin
                rem_reg   <= rem_next;
                quo_reg   <= quo_next;
                count_reg <= count_reg + 6'd1;
            end
        end
    end

    // A flush in DONE belongs to the same instruction, so the write is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if ((state_reg == DONE) && !flush_i) begin
            if (div_op_reg) begin
                hi_reg <= neg_if(r_neg_reg, rem_reg);
                lo_reg <= neg_if(q_neg_reg, quo_reg);
            end else begin
                hi_reg <= prod_reg[63:32];
                lo_reg <= prod_reg[31:0];
            end
        end else if (idle_issue) begin
            if (mthi_i) begin
                hi_reg <= src_a;
            end
            if (mtlo_i) begin
                lo_reg <= src_a;
            end
        end
    end

    assign hi_o = hi_reg;
    assign lo_o = lo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table driven through a result
// scoreboard, plus flush, back-to-back and reset corner sequences.
module tb_mdu_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        valid_i = 1'b0;
    logic [7:0]  aluop_i = 8'h00;
    logic        mthi_i = 1'b0;
    logic        mtlo_i = 1'b0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush_i = 1'b0;
    logic        stall_o;
    logic        busy_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    mdu_ctrl dut (
        .clk     (clk),
        .resetn  (resetn),
        .valid_i (valid_i),
        .aluop_i (aluop_i),
        .mthi_i  (mthi_i),
        .mtlo_i  (mtlo_i),
        .src_a   (src_a),
        .src_b   (src_b),
        .flush_i (flush_i),
        .stall_o (stall_o),
        .busy_o  (busy_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic        mthi;
        logic        mtlo;
        logic [31:0] a;
        logic [31:0] b;
        int          exp_stall;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    vec_t vecs[12];
    res_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_result(input string name);
        res_t r;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("[TB] FAIL %s: scoreboard empty, got hi=%08h lo=%08h", name, hi_o, lo_o);
        end else begin
            r = sb.pop_front();
            check({name, ".hi"}, hi_o, r.hi);
            check({name, ".lo"}, lo_o, r.lo);
        end
    endtask

    // Count stall cycles starting at the current cycle until stall drops.
    task automatic count_stall(output int n);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!stall_o) break;
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        @(posedge clk); #1;
        valid_i = 1'b1;
        aluop_i = v.op;
        mthi_i  = v.mthi;
        mtlo_i  = v.mtlo;
        src_a   = v.a;
        src_b   = v.b;
        sb.push_back('{hi: v.exp_hi, lo: v.exp_lo});
        count_stall(n);
        check({v.name, ".stall"}, 32'(n), 32'(v.exp_stall));
        @(posedge clk); #1;
        valid_i = 1'b0;
        mthi_i  = 1'b0;
        mtlo_i  = 1'b0;
        aluop_i = 8'h00;
        @(negedge clk);
        check({v.name, ".busy"}, 32'(busy_o), 32'd0);
        $display("[TB] %-10s a=%08h b=%08h stall=%0d hi=%08h lo=%08h",
                 v.name, v.a, v.b, n, hi_o, lo_o);
        check_result(v.name);
    endtask

    initial begin
        int n;
        vecs[0]  = '{"mult",      ALU_MULT,  0, 0, 32'hFFFF_FFFE, 32'd3,         2,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{"multu",     ALU_MULTU, 0, 0, 32'hFFFF_FFFE, 32'd3,         2,  32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2]  = '{"div_m7_2",  ALU_DIV,   0, 0, 32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{"divu_100_7",ALU_DIVU,  0, 0, 32'd100,       32'd7,         33, 32'd2,         32'd14};
        vecs[4]  = '{"divu_by0",  ALU_DIVU,  0, 0, 32'h0000_1234, 32'd0,         33, 32'h0000_1234, 32'hFFFF_FFFF};
        vecs[5]  = '{"div_ovf",   ALU_DIV,   0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000};
        vecs[6]  = '{"div_m5_0",  ALU_DIV,   0, 0, 32'hFFFF_FFFB, 32'd0,         33, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[7]  = '{"div_7_m2",  ALU_DIV,   0, 0, 32'd7,         32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8]  = '{"divu_max_1",ALU_DIVU,  0, 0, 32'hFFFF_FFFF, 32'd1,         33, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[9]  = '{"mult_big",  ALU_MULT,  0, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 2,  32'h3FFF_FFFF, 32'h0000_0001};
        vecs[10] = '{"mthi",      8'h00,     1, 0, 32'hAAAA_AAAA, 32'd0,         0,  32'hAAAA_AAAA, 32'h0000_0001};
        vecs[11] = '{"mtlo",      8'h00,     0, 1, 32'h5555_5555, 32'd0,         0,  32'hAAAA_AAAA, 32'h5555_5555};

        // Reset state
        #2 resetn = 1'b0;
        #3;
        check("rst.hi", hi_o, 32'd0);
        check("rst.lo", lo_o, 32'd0);
        check("rst.stall", 32'(stall_o), 32'd0);
        check("rst.busy", 32'(busy_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // Flush at divide iteration 10: aborts with HI/LO untouched
        @(posedge clk); #1;
        valid_i = 1'b1; aluop_i = ALU_DIV; src_a = 32'd1000; src_b = 32'd3;
        repeat (10) @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        check("flush.stall_during", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0; aluop_i = 8'h00;
        @(negedge clk);
        $display("[TB] flush_div  stall=%0d busy=%0d hi=%08h lo=%08h", stall_o, busy_o, hi_o, lo_o);
        check("flush.stall", 32'(stall_o), 32'd0);
        check("flush.busy", 32'(busy_o), 32'd0);
        check("flush.hi", hi_o, 32'hAAAA_AAAA);
        check("flush.lo", lo_o, 32'h5555_5555);
        repeat (40) @(negedge clk);
        check("flush.hi_later", hi_o, 32'hAAAA_AAAA);
        check("flush.lo_later", lo_o, 32'h5555_5555);

        // Start presented together with flush is dropped
        @(posedge clk); #1;
        valid_i = 1'b1; aluop_i = ALU_MULT; src_a = 32'd9; src_b = 32'd9; flush_i = 1'b1;
        @(negedge clk);
        check("flushstart.stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        valid_i = 1'b0; aluop_i = 8'h00; flush_i = 1'b0;
        @(negedge clk);
        $display("[TB] flush_start busy=%0d hi=%08h lo=%08h", busy_o, hi_o, lo_o);
        check("flushstart.busy", 32'(busy_o), 32'd0);
        repeat (4) @(negedge clk);
        check("flushstart.lo", lo_o, 32'h5555_5555);

        // Back-to-back DIVU then MULTU with valid held through DONE
        @(posedge clk); #1;
        valid_i = 1'b1; aluop_i = ALU_DIVU; src_a = 32'd100; src_b = 32'd7;
        sb.push_back('{hi: 32'd2, lo: 32'd14});
        count_stall(n);
        check("b2b.div_stall", 32'(n), 32'd33);
        check("b2b.done_busy", 32'(busy_o), 32'd1);
        @(posedge clk); #1;
        aluop_i = ALU_MULTU; src_a = 32'hFFFF_FFFE; src_b = 32'd3;
        sb.push_back('{hi: 32'd2, lo: 32'hFFFF_FFFA});
        @(negedge clk);
        check("b2b.idle_busy", 32'(busy_o), 32'd0);
        check("b2b.mul_start", 32'(stall_o), 32'd1);
        $display("[TB] b2b_divu   hi=%08h lo=%08h", hi_o, lo_o);
        check_result("b2b.div");
        count_stall(n);
        check("b2b.mul_stall", 32'(n), 32'd1);
        @(posedge clk); #1;
        valid_i = 1'b0; aluop_i = 8'h00;
        @(negedge clk);
        $display("[TB] b2b_multu  hi=%08h lo=%08h", hi_o, lo_o);
        check_result("b2b.mul");

        // Asynchronous reset in the middle of a multiply
        @(posedge clk); #1;
        valid_i = 1'b1; aluop_i = ALU_MULT; src_a = 32'd5; src_b = 32'd6;
        @(posedge clk); #2;
        resetn = 1'b0; valid_i = 1'b0; aluop_i = 8'h00;
        #1;
        $display("[TB] reset_mid  stall=%0d busy=%0d hi=%08h lo=%08h", stall_o, busy_o, hi_o, lo_o);
        check("rstmid.hi", hi_o, 32'd0);
        check("rstmid.lo", lo_o, 32'd0);
        check("rstmid.stall", 32'(stall_o), 32'd0);
        check("rstmid.busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b1; mtlo_i = 1'b1; src_a = 32'd1;
        @(negedge clk);
        check("mtlo.stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        valid_i = 1'b0; mtlo_i = 1'b0;
        @(negedge clk);
        $display("[TB] mtlo_1     hi=%08h lo=%08h", hi_o, lo_o);
        check("mtlo.lo", lo_o, 32'd1);
        check("mtlo.hi", hi_o, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
